// File: rtl/audio_pkg.sv
// Shared definitions for the audio pattern path. The player and this loader both use these,
// so the pattern reset value is defined in one place only.
package audio_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } fetch_state_e;

  localparam int PATTERN_BYTES = 16;
  localparam logic [8*PATTERN_BYTES-1:0] DEFAULT_PATTERN =
    128'h0000ffff0000ffff0000ffff0000ffff;
endpackage

// File: rtl/audio_pattern_loader_sound_timer.sv
// 8-bit sound timer: loadable down-counter that stops at zero; a load beats a tick.
module audio_pattern_loader_sound_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_i,
  input  logic [7:0] value_i,
  input  logic       tick_i,
  output logic [7:0] count_o,
  output logic       active_o
);
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (write_i) begin
      count_d = value_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign active_o = (count_q != 8'd0);
endmodule

// File: rtl/audio_pattern_loader.sv
// Fetches a byte-wide audio pattern over req/ack, assembles it MSB-first and strobes it
// into the square-wave player; also hosts the 60 Hz sound timer.
module audio_pattern_loader
  import audio_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PATTERN_BYTES = audio_pkg::PATTERN_BYTES,
  parameter logic [8*PATTERN_BYTES-1:0] DEFAULT_PATTERN = audio_pkg::DEFAULT_PATTERN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       busy,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic                       mem_ack,
  input  logic [7:0]                 mem_data,
  output logic [8*PATTERN_BYTES-1:0] pattern_out,
  output logic                       load_pattern,
  input  logic                       timer_write,
  input  logic [7:0]                 timer_value,
  input  logic                       tick_60hz,
  output logic [7:0]                 sound_timer,
  output logic                       sound_enable
);
  localparam int PW = 8 * PATTERN_BYTES;
  localparam int IW = (PATTERN_BYTES > 1) ? $clog2(PATTERN_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PATTERN_BYTES - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         asm_q, asm_d;
  logic [PW-1:0]         pattern_q, pattern_d;
  logic [PW-1:0]         asm_shifted;

  // Shifting left means the first byte fetched ends up in the top byte.
  assign asm_shifted = {asm_q[PW-9:0], mem_data};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    pattern_d    = pattern_q;
    busy         = 1'b0;
    mem_req      = 1'b0;
    load_pattern = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          asm_d  = asm_shifted;
          addr_d = addr_q + ADDR_WIDTH'(1);
          idx_d  = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            pattern_d = asm_shifted;
            state_d   = COMMIT;
          end
        end
      end
      COMMIT: begin
        busy         = 1'b1;
        load_pattern = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      pattern_q <= DEFAULT_PATTERN;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      pattern_q <= pattern_d;
    end
  end

  assign mem_addr    = addr_q;
  assign pattern_out = pattern_q;

  audio_pattern_loader_sound_timer u_sound_timer (
    .clock    (clock),
    .reset    (reset),
    .write_i  (timer_write),
    .value_i  (timer_value),
    .tick_i   (tick_60hz),
    .count_o  (sound_timer),
    .active_o (sound_enable)
  );
endmodule

// File: tb/tb_audio_pattern_loader.sv
// Self-checking bench for audio_pattern_loader: directed fetch scenarios, a timer vector
// table and a randomized timer run with a concurrent fetch, against a behavioural model.
module tb_audio_pattern_loader;
  localparam logic [127:0] DEF = 128'h0000ffff0000ffff0000ffff0000ffff;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = 16'h0;
  logic         busy, mem_req, mem_ack, load_pattern, sound_enable;
  logic [15:0]  mem_addr;
  logic [7:0]   mem_data;
  logic [127:0] pattern_out;
  logic         timer_write = 1'b0;
  logic [7:0]   timer_value = 8'h0;
  logic         tick_60hz = 1'b0;
  logic [7:0]   sound_timer;

  always #5 clock = ~clock;

  audio_pattern_loader dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pattern_out(pattern_out), .load_pattern(load_pattern), .timer_write(timer_write),
    .timer_value(timer_value), .tick_60hz(tick_60hz), .sound_timer(sound_timer),
    .sound_enable(sound_enable)
  );

  logic [7:0] mem [0:65535];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory responder and bus monitor share one process so their order is fixed.
  bit           ack_hold = 1'b0;
  int           ack_wait = 0;
  int           wcnt = 0;
  logic [15:0]  acked[$];
  int           stable_err = 0, loads = 0, load_cyc = -1, last_busy_cyc = -1, glitch = 0;
  logic [127:0] load_val = '0, prev_pat = '0;
  bit           prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0]  prev_addr = '0;

  always @(negedge clock) begin
    if (ack_hold) begin
      mem_ack = 1'b1; mem_data = mem[mem_addr];
    end else if (!mem_req) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (wcnt >= ack_wait) begin
      mem_ack = 1'b1; mem_data = mem[mem_addr]; wcnt = 0;
    end else begin
      mem_ack = 1'b0; wcnt++;
    end
    if (mem_req && mem_ack) acked.push_back(mem_addr);
    if (mem_req && prev_req && !prev_ack && (mem_addr != prev_addr)) stable_err++;
    if (busy && !load_pattern && (pattern_out != prev_pat)) glitch++;
    if (load_pattern) begin
      loads++; load_cyc = cyc; load_val = pattern_out;
    end
    if (busy) last_busy_cyc = cyc;
    prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr; prev_pat = pattern_out;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    acked.delete();
    loads = 0; load_cyc = -1; last_busy_cyc = -1; stable_err = 0; glitch = 0;
  endtask

  // Expected pattern: byte k of the fetch occupies bits [127-8k -: 8].
  function automatic logic [127:0] expect_pattern(input logic [15:0] base);
    logic [127:0] p = '0;
    for (int k = 0; k < 16; k++) p[127 - 8*k -: 8] = mem[16'(base + k)];
    return p;
  endfunction

  task automatic fill_random(input logic [15:0] base);
    for (int k = 0; k < 16; k++) mem[16'(base + k)] = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(loads > 0 && !busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_done"}, {127'b0, (loads > 0 && !busy)}, 128'd1);
    $display("fetch %s: loads=%0d pattern=%h", name, loads, load_val);
  endtask

  task automatic check_addrs(input string name, input logic [15:0] base);
    check({name, "_nacks"}, acked.size(), 128'd16);
    for (int k = 0; k < 16 && k < acked.size(); k++)
      check($sformatf("%s_addr%0d", name, k), acked[k], 16'(base + k));
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] val;
    bit         tk;
    logic [7:0] exp_t;
    bit         exp_en;
  } tvec_t;

  initial begin
    tvec_t tv[$];
    int c0;
    logic [15:0] rb;
    logic [7:0] tmodel;

    // Reset state
    repeat (3) step();
    check("rst_pattern", pattern_out, DEF);
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_load", load_pattern, 0);
    check("rst_timer", sound_timer, 0);
    check("rst_enable", sound_enable, 0);
    reset = 1'b1;
    step();
    check("rel_pattern", pattern_out, DEF);
    check("rel_busy", busy, 0);

    // Zero-wait fetch, ack held high throughout, start again during COMMIT
    for (int k = 0; k < 16; k++) mem[16'h0200 + k] = 8'(k + 1);
    ack_hold = 1'b1;
    clear_mon();
    start = 1'b1; base_addr = 16'h0200; c0 = cyc;
    step();
    start = 1'b0; base_addr = 16'hAAAA;
    repeat (16) step();
    start = 1'b1; base_addr = 16'h5555;
    step();
    start = 1'b0;
    wait_done("zero_wait", 40);
    check_addrs("zero_wait", 16'h0200);
    check("zw_loads", loads, 1);
    check("zw_load_cycle", load_cyc - c0, 17);
    check("zw_busy_last_cycle", last_busy_cyc - c0, 17);
    check("zw_pattern", load_val, 128'h0102030405060708090a0b0c0d0e0f10);
    check("zw_glitch", glitch, 0);
    repeat (3) step();
    check("zw_commit_start_busy", busy, 0);
    check("zw_commit_start_loads", loads, 1);
    check("zw_pattern_held", pattern_out, 128'h0102030405060708090a0b0c0d0e0f10);
    ack_hold = 1'b0;

    // Wait states, address wrap, and a second start mid-fetch
    fill_random(16'hFFFE);
    ack_wait = 2;
    clear_mon();
    start = 1'b1; base_addr = 16'hFFFE;
    step();
    start = 1'b0;
    repeat (10) step();
    start = 1'b1; base_addr = 16'h1234;
    step();
    start = 1'b0;
    wait_done("wrap", 100);
    check_addrs("wrap", 16'hFFFE);
    check("wrap_stable", stable_err, 0);
    check("wrap_glitch", glitch, 0);
    check("wrap_pattern", load_val, expect_pattern(16'hFFFE));
    repeat (5) step();
    check("wrap_loads", loads, 1);
    check("wrap_idle", busy, 0);

    // Reset in the middle of a fetch
    timer_write = 1'b1; timer_value = 8'd9;
    step();
    timer_write = 1'b0;
    fill_random(16'h0300);
    ack_wait = 1;
    clear_mon();
    start = 1'b1; base_addr = 16'h0300;
    step();
    start = 1'b0;
    for (int n = 0; n < 40 && acked.size() < 5; n++) step();
    check("mid_reached_5_acks", {127'b0, (acked.size() >= 5)}, 128'd1);
    reset = 1'b0;
    step();
    check("mid_req", mem_req, 0);
    check("mid_busy", busy, 0);
    check("mid_pattern", pattern_out, DEF);
    check("mid_timer", sound_timer, 0);
    reset = 1'b1;
    repeat (5) step();
    check("mid_no_load", loads, 0);
    check("mid_pattern_after", pattern_out, DEF);
    fill_random(16'h0400);
    clear_mon();
    start = 1'b1; base_addr = 16'h0400;
    step();
    start = 1'b0;
    wait_done("after_reset", 80);
    check_addrs("after_reset", 16'h0400);
    check("after_reset_pattern", load_val, expect_pattern(16'h0400));
    check("after_reset_loads", loads, 1);

    // Timer vector table
    tv.push_back('{1'b1, 8'd3,   1'b0, 8'd3,   1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'd2,   1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'd1,   1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'd0,   1'b0});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'd0,   1'b0});
    tv.push_back('{1'b1, 8'h05,  1'b1, 8'h05,  1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b0, 8'h05,  1'b1});
    tv.push_back('{1'b1, 8'h00,  1'b0, 8'h00,  1'b0});
    tv.push_back('{1'b1, 8'hFF,  1'b0, 8'hFF,  1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'hFE,  1'b1});
    tv.push_back('{1'b1, 8'h01,  1'b0, 8'h01,  1'b1});
    tv.push_back('{1'b0, 8'd0,   1'b1, 8'h00,  1'b0});
    for (int i = 0; i < tv.size(); i++) begin
      timer_write = tv[i].wr; timer_value = tv[i].val; tick_60hz = tv[i].tk;
      step();
      check($sformatf("tv%0d_timer", i), sound_timer, tv[i].exp_t);
      check($sformatf("tv%0d_enable", i), sound_enable, tv[i].exp_en);
      $display("timer vec %0d: wr=%0b val=%02h tick=%0b -> %02h", i, tv[i].wr, tv[i].val,
               tv[i].tk, sound_timer);
    end
    timer_write = 1'b0; tick_60hz = 1'b0;

    // Random timer traffic with a fetch running alongside
    tmodel = 8'h00;
    rb = 16'($urandom);
    fill_random(rb);
    ack_wait = 1;
    clear_mon();
    start = 1'b1; base_addr = rb;
    step();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      timer_write = ($urandom_range(0, 3) == 0);
      timer_value = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      tick_60hz   = ($urandom_range(0, 1) == 1);
      step();
      if (timer_write) tmodel = timer_value;
      else if (tick_60hz && tmodel > 0) tmodel = tmodel - 1;
      check($sformatf("rnd%0d_timer", i), sound_timer, tmodel);
      check($sformatf("rnd%0d_enable", i), sound_enable, {127'b0, (tmodel != 0)});
    end
    timer_write = 1'b0; tick_60hz = 1'b0;
    check("rnd_fetch_loads", loads, 1);
    check("rnd_fetch_pattern", load_val, expect_pattern(rb));
    check_addrs("rnd_fetch", rb);
    $display("random fetch base=%04h pattern=%h", rb, load_val);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/audio_pattern_loader.md
Name: audio_pattern_loader

Overview:
- Feeds the square-wave audio player.
- Fetches a 16-byte audio pattern from byte-wide memory through a req/ack handshake and assembles it into a 128-bit word. It then pulses load_pattern for one cycle so the player latches the word.
- Also owns the 8-bit sound timer. The timer is decremented on the 60 Hz tick, and sound_enable is asserted to the player while the timer is non-zero.

Parameters:
- ADDR_WIDTH, 16, width of memory byte address; address arithmetic wraps modulo 2^ADDR_WIDTH.
- PATTERN_BYTES, 16, bytes per pattern; pattern width = 8*PATTERN_BYTES.
- DEFAULT_PATTERN, 128'h0000ffff0000ffff0000ffff0000ffff, pattern_out reset value.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low
- start  input  1  one-cycle request to fetch a pattern from base_addr
- base_addr  input  ADDR_WIDTH  address of first pattern byte, sampled when start is accepted
- busy  output  1  high from start acceptance until the cycle after load_pattern
- mem_req  output  1  memory read request
- mem_addr  output  ADDR_WIDTH  read address; stable while mem_req is high
- mem_ack  input  1  memory has data for the current request
- mem_data  input  8  read data, valid in the cycle mem_ack is high
- pattern_out  output  8*PATTERN_BYTES  assembled pattern to the player
- load_pattern  output  1  one-cycle strobe; pattern_out is valid in that cycle
- timer_write  input  1  load sound timer
- timer_value  input  8  value for timer_write
- tick_60hz  input  1  one-cycle decrement strobe
- sound_timer  output  8  current timer value
- sound_enable  output  1  sound_timer != 0 (combinational from register)

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE; busy=0, mem_req=0, mem_addr=0, load_pattern=0.
  - pattern_out=DEFAULT_PATTERN; sound_timer=0, sound_enable=0.
  - Overrides all other inputs that cycle.
- FSM states IDLE, FETCH, COMMIT.
- IDLE, start=1:
  - Latch base_addr into mem_addr, clear byte index.
  - Set mem_req=1, busy=1; go to FETCH next cycle.
- start while busy is ignored; it is not queued.
- FETCH:
  - mem_req held high and mem_addr held stable until mem_ack is sampled high.
  - On each ack, mem_data is written into the assembly shift register.
  - Byte 0 (at base_addr) ends in pattern_out[127:120]; byte 15 ends in [7:0]. This is MSB-first, matching the player's step counting down from 127.
  - After each ack, mem_addr increments with wrap (0xFFFF -> 0x0000).
  - mem_req stays high for back-to-back reads, so one byte per cycle is possible when ack is held high.
  - After the ack for byte PATTERN_BYTES-1: mem_req drops and the FSM goes to COMMIT.
- Assembly buffer is separate from pattern_out; pattern_out does not change during FETCH.
- COMMIT, for exactly one cycle:
  - pattern_out is updated with the assembled word on entry to COMMIT.
  - load_pattern=1 for that cycle; then go to IDLE and drop busy.
  - A start in the COMMIT cycle is ignored.
- mem_ack while mem_req=0 is ignored.
- Fetch latency with mem_ack held high:
  - start at cycle 0 -> acks at cycles 1..16 -> load_pattern at cycle 17 -> busy low at cycle 18.
- Reset mid-fetch: fetch is aborted, no load_pattern, pattern_out returns to DEFAULT_PATTERN.
- Sound timer:
  - timer_write=1: sound_timer <= timer_value.
  - Otherwise tick_60hz=1 with sound_timer!=0: decrement by 1.
  - Tick at 0: stays 0, no wrap.
  - Write and tick in the same cycle: write wins, no decrement.
- Timer and fetch FSM are independent; both may be active in the same cycle.

Decomposition:
- Shared package (audio_pkg):
  - FSM state enum {IDLE, FETCH, COMMIT}.
  - PATTERN_BYTES and DEFAULT_PATTERN constants, so the player's pattern reset value and this block's reset value cannot diverge.
- One natural sub-module, sound_timer: 8-bit loadable saturating down-counter with write-priority. Keeps the fetch FSM isolated.

Test Plan:
- Reset released -> pattern_out==128'h0000ffff0000ffff0000ffff0000ffff, busy=0, mem_req=0, sound_enable=0.
- Fetch with zero wait states:
  - Stimulus: base_addr=16'h0200, mem_ack held 1, memory byte at (0x0200+k) = k+1.
  - Required: mem_addr steps 0x0200..0x020F.
  - Required: load_pattern is high only at cycle 17, with pattern_out==128'h0102030405060708090a0b0c0d0e0f10.
  - Required: busy falls at cycle 18.
- Fetch with wait states and wrap:
  - Stimulus: base_addr=16'hFFFE; ack delayed 2 cycles per byte; start pulsed again mid-fetch.
  - Required: addresses FFFE, FFFF, 0000..000D; mem_addr stable while mem_req is high and unacked.
  - Required: the second start has no effect; exactly one load_pattern.
- Reset mid-fetch:
  - Stimulus: reset=0 after 5 acks.
  - Required: mem_req=0, no load_pattern, pattern_out==DEFAULT_PATTERN.
  - Required: a new start afterwards completes normally.
- Timer:
  - Stimulus: write 3; three ticks.
  - Required: sound_timer 3->2->1->0; sound_enable falls with the third tick; a further tick keeps 0.
- Timer simultaneous events:
  - Stimulus: timer_write=1 with timer_value=8'h05 and tick_60hz=1 in the same cycle.
  - Required: sound_timer==5.
  - Stimulus: write 8'h00.
  - Required: sound_enable=0 next cycle.
